pwr_activity_counter: RTL and testbench
=======================================

# pwr_activity_counter

Switching-activity monitor for gate-level power estimation. Samples up to N_PROBES net probes, typically flop Q outputs of a synthesized netlist, once per clock and accumulates their 0→1 transitions into a saturating total. It sits directly downstream of the cell-level netlist under test and replaces per-cell ad-hoc counting with one synthesizable, snapshot-readable counter the probador reads.

## Interface
Parameters:
- N_PROBES, 4: number of probed nets, 1..16.
- CNT_W, 16: width of the accumulated total, ≥ 8.

Ports:
- C  in  1  clock; all state updates on posedge C.
- R  in  1  reset, asynchronous, active-high.
- probe  in  N_PROBES  nets under observation, synchronous to C.
- start  in  1  begin counting.
- stop  in  1  pause counting.
- clear  in  1  zero the total.
- snap_req  in  1  request a snapshot of the total.
- snap_ack  in  1  consumer has taken the snapshot.
- total  out  CNT_W  running count.
- sat  out  1  total has saturated.
- busy  out  1  state is RUN or SAT.
- snap_valid  out  1  snap_count holds a valid snapshot.
- snap_count  out  CNT_W  captured total.

## Operation
- Reset (R=1, any time, mid-count included): state IDLE; p_q, total, sat, busy, snap_valid and snap_count all 0. No edges are counted until start is seen after R is released.
- Edge detect: p_q registers probe every cycle in every state. edges = probe & ~p_q. n = popcount(edges), range 0..N_PROBES.
- Because p_q tracks probe while in IDLE, entering RUN never produces spurious edges from probes that are already high.
- FSM:
  - IDLE: start=1 → RUN.
  - RUN: total += n each cycle. stop=1 → IDLE; the edges of that cycle are still counted. If total+n > 2^CNT_W−1, total becomes 2^CNT_W−1, sat becomes 1, and the state moves to SAT.
  - SAT: total is frozen. Only clear or R exits, to IDLE.
- start and stop both high in IDLE: stays IDLE. Both high in RUN: goes to IDLE.
- clear has priority over accumulation in every state:
  - total ← 0 and sat ← 0.
  - From SAT: next state IDLE.
  - From IDLE with start=1: next state RUN with total 0.
  - From RUN: stays RUN; that cycle's edges are discarded.
- Width rule: the sum is computed CNT_W+1 bits wide and checked before truncation. Wrap-around never occurs.
- Snapshot handshake:
  - snap_req=1 with snap_valid=0: snap_count ← current total register (the value before this cycle's update) and snap_valid ← 1.
  - snap_valid stays high and snap_count stays stable until snap_ack=1 is sampled, then snap_valid ← 0.
  - snap_req while snap_valid=1 is ignored.
  - snap_ack while snap_valid=0 is ignored.
  - snap_req and snap_ack both high while valid: the ack wins and no new capture occurs.
  - clear does not affect a pending snapshot.

## Timing
- Probe rise between edges k−1 and k: p_q is low at edge k and probe is high, so total includes it after edge k (1-cycle latency from the sampled rise).
- start at edge k: edges sampled at edge k+1 are the first ones counted.
- snap_req sampled at edge k: snap_valid=1 and snap_count valid after edge k. snap_ack sampled at edge j>k: snap_valid=0 after edge j. The fastest re-request is at edge j+1.
- busy and sat are registered outputs decoded from state. They have no combinational path from the inputs.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- ACT_BOTH_EDGES_EN defined: edges = probe ^ p_q. Both 0→1 and 1→0 transitions are counted, giving the full toggle count for power estimates.
- ACT_BOTH_EDGES_EN undefined (default): only 0→1 transitions are counted, matching rising-output energy accounting.
- All other behaviour is identical in both builds.

## Test plan
- Reset/idle: assert R mid-RUN with total=37 → next cycle total=0, sat=0, busy=0, snap_valid=0. Toggle probe in IDLE → total stays 0.
- Counting: N_PROBES=4; probe steps 0000→1111→0000→0101 at consecutive cycles in RUN → total=4, then 4, then 6. With ACT_BOTH_EDGES_EN: 4, 8, 10.
- Start with probes high: probe=1111 held in IDLE, start pulse, hold probe for 5 cycles → total stays 0.
- Saturation: CNT_W=8, preload to 253 via counting, then probe 0000→1111 → total=255, sat=1, state SAT. Further edges leave total=255. clear → total=0, sat=0, busy=0.
- Snapshot: total=20, snap_req pulse → snap_count=20, snap_valid=1. Counting continues to 30 while snap_count stays 20. A second snap_req is ignored. snap_ack → snap_valid=0 one cycle later.
- Simultaneous events: clear and start in IDLE with total=9 → RUN, total=0. snap_req and snap_ack together while valid → snap_valid=0 and snap_count unchanged.

Source files
------------

// File: rtl/pwr_activity_counter.sv
// ============================================================================
// Module      : pwr_activity_counter
// Description : Switching-activity monitor. Counts probe transitions into a
//               saturating total and offers a snapshot/ack readout.
//               Optional macro ACT_BOTH_EDGES_EN: count both 0->1 and 1->0
//               transitions (default: rising transitions only).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwr_activity_counter #(
    parameter int N_PROBES = 4,
    parameter int CNT_W    = 16
) (
    input  logic                C,
    input  logic                R,
    input  logic [N_PROBES-1:0] probe,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                snap_req,
    input  logic                snap_ack,
    output logic [CNT_W-1:0]    total,
    output logic                sat,
    output logic                busy,
    output logic                snap_valid,
    output logic [CNT_W-1:0]    snap_count
);

    localparam int N_W = $clog2(N_PROBES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_PROBES-1:0]   r_p_q;
    logic [CNT_W-1:0]      r_total;
    logic [CNT_W-1:0]      w_total_nxt;
    logic                  r_sat;
    logic                  r_busy;
    logic                  r_snap_valid;
    logic [CNT_W-1:0]      r_snap_count;

    logic [N_PROBES-1:0]   w_edges;
    logic [N_W-1:0]        w_n;
    logic [CNT_W:0]        w_sum;
    logic                  w_ovf;

    // ------------------------------------------------------------------------
    // Edge detection and population count
    // ------------------------------------------------------------------------
`ifdef ACT_BOTH_EDGES_EN
    assign w_edges = probe ^ r_p_q;
`else
    assign w_edges = probe & ~r_p_q;
`endif

    always_comb begin
        w_n = '0;
        for (int i = 0; i < N_PROBES; i++) begin
            w_n = w_n + N_W'(w_edges[i]);
        end
    end

    // One extra bit so overflow is visible before truncation.
    assign w_sum = {1'b0, r_total} + (CNT_W + 1)'(w_n);
    assign w_ovf = w_sum[CNT_W];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_p_q   <= '0;
            r_total <= '0;
            r_sat   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p_q   <= probe;
            r_total <= w_total_nxt;
            r_sat   <= (w_state_nxt == ST_SAT);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and accumulator logic; clear beats accumulation everywhere
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_total_nxt = r_total;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_total_nxt = '0;
                end
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    w_total_nxt = '0;
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_ovf) begin
                    w_total_nxt = '1;
                    w_state_nxt = ST_SAT;
                end else begin
                    w_total_nxt = w_sum[CNT_W-1:0];
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_SAT: begin
                if (clear) begin
                    w_total_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_total_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Snapshot handshake: ack wins over a concurrent request
    // ------------------------------------------------------------------------
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_snap_valid <= 1'b0;
            r_snap_count <= '0;
        end else if (r_snap_valid) begin
            if (snap_ack) begin
                r_snap_valid <= 1'b0;
            end
        end else if (snap_req) begin
            r_snap_valid <= 1'b1;
            r_snap_count <= r_total;
        end
    end

    assign total      = r_total;
    assign sat        = r_sat;
    assign busy       = r_busy;
    assign snap_valid = r_snap_valid;
    assign snap_count = r_snap_count;

endmodule

`default_nettype wire

// File: tb/tb_pwr_activity_counter.sv
// ============================================================================
// Module      : tb_pwr_activity_counter
// Description : Self-checking bench: vector table, directed corner sequences
//               and random stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwr_activity_counter;

    localparam int NP   = 4;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;
`ifdef ACT_BOTH_EDGES_EN
    localparam int BOTH = 1;
`else
    localparam int BOTH = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] probe = '0;
    logic          start = 0, stop = 0, clear = 0, snap_req = 0, snap_ack = 0;
    logic [CW-1:0] total, snap_count;
    logic          sat, busy, snap_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model
    bit      m_run, m_sat, m_valid;
    int      m_total, m_snap;
    logic [NP-1:0] m_prev;

    pwr_activity_counter #(.N_PROBES(NP), .CNT_W(CW)) dut (
        .C(clk), .R(rst), .probe(probe), .start(start), .stop(stop),
        .clear(clear), .snap_req(snap_req), .snap_ack(snap_ack),
        .total(total), .sat(sat), .busy(busy), .snap_valid(snap_valid),
        .snap_count(snap_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_sat = 0; m_valid = 0; m_total = 0; m_snap = 0; m_prev = '0;
    endtask

    task automatic model_step();
        int n;
        int old_total;
        logic [NP-1:0] e;
`ifdef ACT_BOTH_EDGES_EN
        e = probe ^ m_prev;
`else
        e = probe & ~m_prev;
`endif
        n = $countones(e);
        old_total = m_total;
        if (m_run) begin
            if (clear) begin
                m_total = 0;
                if (stop) m_run = 0;
            end else if (m_total + n > MAXV) begin
                m_total = MAXV; m_sat = 1; m_run = 0;
            end else begin
                m_total = m_total + n;
                if (stop) m_run = 0;
            end
        end else if (m_sat) begin
            if (clear) begin m_total = 0; m_sat = 0; end
        end else begin
            if (clear) m_total = 0;
            if (start && !stop) m_run = 1;
        end
        if (m_valid) begin
            if (snap_ack) m_valid = 0;
        end else if (snap_req) begin
            m_valid = 1; m_snap = old_total;
        end
        m_prev = probe;
    endtask

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        n_cmp++;
        if (int'(total) != m_total || sat != m_sat || busy != (m_run || m_sat) ||
            snap_valid != m_valid || int'(snap_count) != m_snap) begin
            n_err++;
            $display("FAIL %s: got total=%0d sat=%0b busy=%0b sv=%0b sc=%0d expected total=%0d sat=%0b busy=%0b sv=%0b sc=%0d",
                     tag, total, sat, busy, snap_valid, snap_count,
                     m_total, m_sat, (m_run || m_sat), m_valid, m_snap);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clear = 0; snap_req = 0; snap_ack = 0;
    endtask

    // Toggle probe[0] until the model total reaches target (must be in RUN).
    task automatic count_to(input int target);
        for (int i = 0; i < 2000 && m_total != target; i++) begin
            probe[0] = ~probe[0];
            tick("count_to");
        end
        check("count_to_total", int'(total), target);
    endtask

    typedef struct {
        logic [NP-1:0] probe;
        logic start, stop, clear, req, ack;
        int   e_total;
        bit   e_sat, e_busy, e_valid;
        int   e_snap;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{4'h0, 1, 0, 0, 0, 0, 0,            0, 1, 0, 0};
        tbl[1] = '{4'hF, 0, 0, 0, 0, 0, 4,            0, 1, 0, 0};
        tbl[2] = '{4'h0, 0, 0, 0, 0, 0, 4 + 4*BOTH,   0, 1, 0, 0};
        tbl[3] = '{4'h5, 0, 0, 0, 0, 0, 6 + 4*BOTH,   0, 1, 0, 0};
        tbl[4] = '{4'h5, 0, 1, 0, 0, 0, 6 + 4*BOTH,   0, 0, 0, 0};
        tbl[5] = '{4'hA, 0, 0, 0, 0, 0, 6 + 4*BOTH,   0, 0, 0, 0};
        tbl[6] = '{4'hA, 0, 0, 0, 1, 0, 6 + 4*BOTH,   0, 0, 1, 6 + 4*BOTH};
        tbl[7] = '{4'hA, 0, 0, 0, 0, 1, 6 + 4*BOTH,   0, 0, 0, 6 + 4*BOTH};
        tbl[8] = '{4'hA, 1, 0, 1, 0, 0, 0,            0, 1, 0, 6 + 4*BOTH};
        tbl[9] = '{4'hF, 0, 0, 0, 0, 0, 2,            0, 1, 0, 6 + 4*BOTH};

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_model("reset_state");

        // Vector table
        for (int i = 0; i < 10; i++) begin
            probe = tbl[i].probe; start = tbl[i].start; stop = tbl[i].stop;
            clear = tbl[i].clear; snap_req = tbl[i].req; snap_ack = tbl[i].ack;
            tick("table_model");
            n_cmp++;
            if (int'(total) != tbl[i].e_total || sat != tbl[i].e_sat ||
                busy != tbl[i].e_busy || snap_valid != tbl[i].e_valid ||
                int'(snap_count) != tbl[i].e_snap) begin
                n_err++;
                $display("FAIL table[%0d]: got total=%0d sat=%0b busy=%0b sv=%0b sc=%0d expected %0d %0b %0b %0b %0d",
                         i, total, sat, busy, snap_valid, snap_count, tbl[i].e_total,
                         tbl[i].e_sat, tbl[i].e_busy, tbl[i].e_valid, tbl[i].e_snap);
            end
        end
        idle_inputs();

        // Asynchronous reset mid-run at total=37
        count_to(37);
        rst = 1;
        #2;
        check("async_rst_total", int'(total), 0);
        check("async_rst_flags", {sat, busy, snap_valid}, 0);
        @(posedge clk); #1 rst = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            probe = probe ^ 4'hF;
            tick("idle_toggle");
        end
        check("idle_no_count", int'(total), 0);

        // Start with probes already high
        probe = 4'hF; tick("hold_high");
        start = 1; tick("start_high");
        start = 0;
        repeat (5) tick("hold_high_run");
        check("start_high_total", int'(total), 0);
        check("start_high_busy", busy, 1);

        // Snapshot handshake
        count_to(20);
        snap_req = 1; tick("snap_req");
        snap_req = 0;
        check("snap_count_20", int'(snap_count), 20);
        check("snap_valid_1", snap_valid, 1);
        count_to(30);
        snap_req = 1; tick("snap_req_ignored");
        snap_req = 0;
        check("snap_hold_20", int'(snap_count), 20);
        snap_ack = 1; tick("snap_ack");
        snap_ack = 0;
        check("snap_ack_clears", snap_valid, 0);

        // Saturation
        clear = 1; tick("clear_run");
        clear = 0;
        count_to(253);
        probe = 4'h0; tick("sat_pre");
        probe = 4'hF; tick("sat_hit");
        check("sat_total", int'(total), MAXV);
        check("sat_flag", sat, 1);
        for (int i = 0; i < 4; i++) begin
            probe = probe ^ 4'hF;
            tick("sat_frozen");
        end
        check("sat_frozen_total", int'(total), MAXV);
        clear = 1; tick("sat_clear");
        clear = 0;
        check("sat_clear_total", int'(total), 0);
        check("sat_clear_flags", {sat, busy}, 0);

        // Clear+start in IDLE with total=9; req+ack while valid
        start = 1; tick("restart");
        start = 0;
        count_to(9);
        stop = 1; tick("stop");
        stop = 0;
        check("stop_idle_total", int'(total), 9);
        clear = 1; start = 1; tick("clear_start");
        clear = 0; start = 0;
        check("clear_start_busy", busy, 1);
        check("clear_start_total", int'(total), 0);
        count_to(3);
        snap_req = 1; tick("snap2_req");
        snap_ack = 1; tick("snap2_req_ack");
        snap_req = 0; snap_ack = 0;
        check("req_ack_valid", snap_valid, 0);
        check("req_ack_count", int'(snap_count), 3);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            probe    = NP'($urandom);
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            clear    = ($urandom_range(0, 31) == 0);
            snap_req = ($urandom_range(0, 3) == 0);
            snap_ack = ($urandom_range(0, 3) == 0);
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
